// File: rtl/dec192_iter.sv
// Iterative AES-192 decryptor.
// A request is a 128-bit ciphertext plus a 192-bit key. The key schedule is
// built six words per cycle, then one inverse round runs per cycle. The
// plaintext is held on out until the consumer takes it. A key that matches
// the last fully expanded key can skip the schedule when KEY_REUSE is set.
module dec192_iter #(
  parameter bit KEY_REUSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [191:0] key,
  input  logic [127:0] in,
  output logic [127:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  typedef enum logic [1:0] {IDLE, KEYGEN, ROUNDS, DONE} state_t;

  state_t       state, state_nx;
  logic [2:0]   kcnt;
  logic [3:0]   rnd;
  logic         key_cached;
  logic         reuse_hit;

  logic [127:0] blk;
  logic [191:0] cached_key;
  logic [7:0]   rcon;
  logic [31:0]  cur6 [6];
  logic [31:0]  nw   [6];
  logic [5:0]   widx [6];
  logic [31:0]  w    [52];
  logic [31:0]  temp;
  logic [31:0]  acc;
  logic [5:0]   base;
  logic [5:0]   rk_idx;
  logic [127:0] rk_sel, isb, sum, round_out;

  // GF(2^8) multiply by x modulo the AES polynomial
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x6   = gmul(x3, x3);
    x12  = gmul(x6, x6);
    x15  = gmul(x12, x3);
    x30  = gmul(x15, x15);
    x60  = gmul(x30, x30);
    x120 = gmul(x60, x60);
    x240 = gmul(x120, x120);
    x252 = gmul(x240, x12);
    return gmul(x252, x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] i;
    i = gf_inv(a);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^
           {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  // Undo the affine map first, then invert in the field
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] t;
    t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(t);
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] x);
    logic [31:0] r;
    r = {x[23:0], x[31:24]};
    return {sbox(r[31:24]), sbox(r[23:16]), sbox(r[15:8]), sbox(r[7:0])};
  endfunction

  // Byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = a[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] a);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++)
      o[127-8*n -: 8] = inv_sbox(a[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] a);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = a[127-32*c -: 8];
      a1 = a[119-32*c -: 8];
      a2 = a[111-32*c -: 8];
      a3 = a[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Key-schedule step, round-key select and one inverse round
  always_comb begin
    temp = sub_rot_word(cur6[5]) ^ {rcon, 24'h000000};
    acc  = temp;
    base = {3'b000, kcnt} * 6'd6;
    for (int j = 0; j < 6; j++) begin
      acc     = acc ^ cur6[j];
      nw[j]   = acc;
      widx[j] = base + 6'd6 + 6'(j);
    end
    rk_idx    = {rnd, 2'b00};
    rk_sel    = {w[rk_idx], w[rk_idx + 6'd1], w[rk_idx + 6'd2], w[rk_idx + 6'd3]};
    isb       = inv_sub_bytes(inv_shift_rows(blk));
    sum       = isb ^ rk_sel;
    round_out = inv_mix_columns(sum);
    reuse_hit = KEY_REUSE && key_cached && (key == cached_key);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = reuse_hit ? ROUNDS : KEYGEN;
      KEYGEN:  if (kcnt == 3'd7) state_nx = ROUNDS;
      ROUNDS:  if (rnd == 4'd0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Counters, cache flag and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt       <= 3'd0;
      rnd        <= 4'd0;
      key_cached <= 1'b0;
      out        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          kcnt <= 3'd0;
          rnd  <= 4'd12;
          // The cached schedule is about to be overwritten on a miss
          if (!reuse_hit) key_cached <= 1'b0;
        end
        KEYGEN: begin
          kcnt <= kcnt + 3'd1;
          if (kcnt == 3'd7) key_cached <= 1'b1;
        end
        ROUNDS: begin
          rnd <= rnd - 4'd1;
          if (rnd == 4'd0) out <= sum;
        end
        default: ;
      endcase
    end
  end

  // Datapath: cipher state, round-key words and the key cache
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        blk  <= in;
        rcon <= 8'h01;
        for (int j = 0; j < 6; j++) begin
          cur6[j] <= key[191-32*j -: 32];
          w[j]    <= key[191-32*j -: 32];
        end
        if (!reuse_hit) cached_key <= key;
      end
      KEYGEN: begin
        rcon <= xt(rcon);
        for (int j = 0; j < 6; j++) begin
          cur6[j] <= nw[j];
          // The last step produces w52/w53, which no round uses
          if (widx[j] <= 6'd51) w[widx[j]] <= nw[j];
        end
      end
      ROUNDS: begin
        if (rnd == 4'd12) blk <= blk ^ rk_sel;
        else              blk <= round_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dec192_iter.sv
// Bench for dec192_iter: a table-driven AES-192 encryptor produces the
// ciphertexts, and a small cache model predicts the latency of each request.
module tb_dec192_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_valid0 = 1'b0;
  logic         out_ready = 1'b0, out_ready0 = 1'b0;
  logic [191:0] key = '0;
  logic [127:0] din = '0;
  logic         in_ready, in_ready0, out_valid, out_valid0;
  logic [127:0] dout, dout0;

  int total = 0;
  int passed = 0;

  bit           model_cached = 1'b0;
  logic [191:0] model_key = '0;
  logic [7:0]   sb [256];

  localparam logic [191:0] KF = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] CF = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] PF = 128'h00112233445566778899aabbccddeeff;

  dec192_iter #(.KEY_REUSE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .key(key), .in(din), .out(dout), .out_valid(out_valid), .out_ready(out_ready)
  );

  dec192_iter #(.KEY_REUSE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .key(key), .in(din), .out(dout0), .out_valid(out_valid0), .out_ready(out_ready0)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Classic S-box generator: walk the field with generator 3 and its inverse
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  // Reference AES-192 encryption on byte arrays
  function automatic logic [127:0] enc192(input logic [191:0] k, input logic [127:0] pt);
    logic [31:0]  w [52];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 6; i++) w[i] = k[191-32*i -: 32];
    rc = 8'h01;
    for (int i = 6; i < 52; i++) begin
      tmp = w[i-1];
      if (i % 6 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-6] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int r = 1; r <= 12; r++) begin
      for (int n = 0; n < 16; n++) s[n] = sb[s[n]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row+4*c] = s[row+4*((c+row)%4)];
      if (r < 12) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int n = 0; n < 16; n++) s[n] = t[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
    end
    res = '0;
    for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
    return res;
  endfunction

  function automatic int exp_lat(input logic [191:0] k);
    return (model_cached && k == model_key) ? 13 : 21;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one request and return once it has been accepted (ok=0 if never ready)
  task automatic start_req(input bit which, input logic [191:0] k, input logic [127:0] ct,
                           output bit ok);
    int n;
    n = 0;
    while (((which ? in_ready0 : in_ready) !== 1'b1) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    ok = ((which ? in_ready0 : in_ready) === 1'b1);
    key = k;
    din = ct;
    if (which) in_valid0 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_valid0 = 1'b0;
  endtask

  // Request and wait for out_valid; lat counts edges after the accepting edge
  task automatic do_req(input bit which, input logic [191:0] k, input logic [127:0] ct,
                        output int lat, output logic [127:0] res);
    bit ok;
    start_req(which, k, ct, ok);
    lat = 0;
    while (((which ? out_valid0 : out_valid) !== 1'b1) && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    if (!ok) lat = 999;
    res = which ? dout0 : dout;
  endtask

  task automatic consume(input bit which);
    if (which) out_ready0 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    out_ready0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (dout !== 128'h0) $display("FAIL reset_out got %h want 0", dout); else passed++;
    total++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready0 got %b want 1", in_ready0); else passed++;
    total++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid0 got %b want 0", out_valid0); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_cached = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    int lat;
    logic [127:0] res;
    do_req(1'b0, KF, CF, lat, res);
    total++; if (lat !== 21) $display("FAIL fips_latency got %0d want 21", lat); else passed++;
    total++; if (res !== PF) $display("FAIL fips_plaintext got %h want %h", res, PF); else passed++;
    consume(1'b0);
    model_cached = 1'b1;
    model_key = KF;
    total++; if (in_ready !== 1'b1) $display("FAIL fips_idle_after got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_reuse();
    int lat;
    logic [127:0] res, pt, ct;
    pt = rnd128();
    ct = enc192(KF, pt);
    do_req(1'b0, KF, ct, lat, res);
    total++; if (lat !== 13) $display("FAIL reuse_latency got %0d want 13", lat); else passed++;
    total++; if (res !== pt) $display("FAIL reuse_plaintext got %h want %h", res, pt); else passed++;
    consume(1'b0);
  endtask

  task automatic test_no_reuse();
    int lat;
    logic [127:0] res, pt, ct;
    do_req(1'b1, KF, CF, lat, res);
    total++; if (lat !== 21) $display("FAIL noreuse_latency1 got %0d want 21", lat); else passed++;
    total++; if (res !== PF) $display("FAIL noreuse_plaintext1 got %h want %h", res, PF); else passed++;
    consume(1'b1);
    pt = rnd128();
    ct = enc192(KF, pt);
    do_req(1'b1, KF, ct, lat, res);
    total++; if (lat !== 21) $display("FAIL noreuse_latency2 got %0d want 21", lat); else passed++;
    total++; if (res !== pt) $display("FAIL noreuse_plaintext2 got %h want %h", res, pt); else passed++;
    consume(1'b1);
  endtask

  task automatic test_round_trip();
    int lat, el;
    logic [127:0] res, pt, ct;
    logic [191:0] k;
    k = rnd192();
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 5))
        0, 1: k = rnd192();
        2:    k = KF;
        default: ;
      endcase
      pt = rnd128();
      ct = enc192(k, pt);
      el = exp_lat(k);
      do_req(1'b0, k, ct, lat, res);
      total++; if (lat !== el) $display("FAIL rt_latency[%0d] got %0d want %0d", i, lat, el); else passed++;
      total++; if (res !== pt) $display("FAIL rt_plaintext[%0d] got %h want %h", i, res, pt); else passed++;
      model_cached = 1'b1;
      model_key = k;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      consume(1'b0);
    end
  endtask

  task automatic test_backpressure();
    int lat, el;
    logic [127:0] res, pt, ct;
    logic [191:0] k;
    k = rnd192();
    pt = rnd128();
    ct = enc192(k, pt);
    el = exp_lat(k);
    do_req(1'b0, k, ct, lat, res);
    total++; if (lat !== el) $display("FAIL bp_latency got %0d want %0d", lat, el); else passed++;
    total++; if (res !== pt) $display("FAIL bp_plaintext got %h want %h", res, pt); else passed++;
    model_cached = 1'b1;
    model_key = k;
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        key = rnd192();
        din = rnd128();
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      total++; if (dout !== pt) $display("FAIL bp_out_stable[%0d] got %h want %h", c, dout, pt); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got %b want 1", c, out_valid); else passed++;
      total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", c, in_ready); else passed++;
    end
    in_valid = 1'b0;
    consume(1'b0);
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got %b want 0", out_valid); else passed++;
    total++; if (dout !== pt) $display("FAIL bp_release_out got %h want %h", dout, pt); else passed++;
    for (int c = 0; c < 3; c++) begin
      total++; if (in_ready !== 1'b1) $display("FAIL bp_idle_ready[%0d] got %b want 1", c, in_ready); else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic mid_reset(input string tag);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL %s_out_valid got %b want 0", tag, out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL %s_in_ready got %b want 1", tag, in_ready); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_cached = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    logic [127:0] res, pt, ct;
    logic [191:0] ka, kb;
    ka = rnd192();
    kb = rnd192();
    // Reset while the schedule is at kcnt=3
    start_req(1'b0, ka, enc192(ka, rnd128()), ok);
    repeat (3) @(posedge clk);
    #1;
    mid_reset("rst_keygen");
    pt = rnd128(); ct = enc192(ka, pt);
    do_req(1'b0, ka, ct, lat, res);
    total++; if (lat !== 21) $display("FAIL rst_keygen_latency got %0d want 21", lat); else passed++;
    total++; if (res !== pt) $display("FAIL rst_keygen_plaintext got %h want %h", res, pt); else passed++;
    consume(1'b0);
    model_cached = 1'b1; model_key = ka;
    pt = rnd128(); ct = enc192(ka, pt);
    do_req(1'b0, ka, ct, lat, res);
    total++; if (lat !== 13) $display("FAIL rst_cache_latency got %0d want 13", lat); else passed++;
    total++; if (res !== pt) $display("FAIL rst_cache_plaintext got %h want %h", res, pt); else passed++;
    consume(1'b0);
    // Reset at rnd=6: 8 schedule edges plus 6 round edges after the accept
    start_req(1'b0, kb, enc192(kb, rnd128()), ok);
    repeat (14) @(posedge clk);
    #1;
    mid_reset("rst_rounds");
    pt = rnd128(); ct = enc192(kb, pt);
    do_req(1'b0, kb, ct, lat, res);
    total++; if (lat !== 21) $display("FAIL rst_rounds_latency got %0d want 21", lat); else passed++;
    total++; if (res !== pt) $display("FAIL rst_rounds_plaintext got %h want %h", res, pt); else passed++;
    consume(1'b0);
    model_cached = 1'b1; model_key = kb;
  endtask

  task automatic test_back_to_back();
    logic [127:0] pts [5];
    logic [127:0] cts [5];
    logic [191:0] k;
    int sent, got;
    bit rdy, ov, acc;
    logic [127:0] o;
    k = rnd192();
    for (int i = 0; i < 5; i++) begin
      pts[i] = rnd128();
      cts[i] = enc192(k, pts[i]);
    end
    sent = 0;
    got = 0;
    key = k;
    din = cts[0];
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 600 && got < 5; cyc++) begin
      rdy = in_ready;
      ov = out_valid;
      o = dout;
      if (ov) begin
        total++; if (o !== pts[got]) $display("FAIL b2b_plaintext[%0d] got %h want %h", got, o, pts[got]); else passed++;
        got++;
      end
      acc = rdy && in_valid;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 5) din = cts[sent];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (got !== 5) $display("FAIL b2b_outputs got %0d want 5", got); else passed++;
    total++; if (sent !== 5) $display("FAIL b2b_accepts got %0d want 5", sent); else passed++;
    model_cached = 1'b1;
    model_key = k;
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_reuse();
    test_no_reuse();
    test_round_trip();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dec192_iter.md
Name: dec192_iter

Overview:
Iterative AES-192 decryptor: the inverse of the fully unrolled combinational AES-192 encryptor in this codebase.
- Accepts a 128-bit ciphertext and a 192-bit key over a valid/ready handshake.
- Expands the key sequentially, runs one inverse round per cycle, and returns the plaintext over a valid/ready handshake.
- Sits on the receive side of the crypto datapath and reuses the existing key_expansion_192 step; adds combinational inverse helpers (inverse SubBytes, inverse ShiftRows, inverse MixColumns).

Parameters:
KEY_REUSE, 1, when 1, skip key expansion if the accepted key equals the key already expanded and cached.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  ciphertext/key request valid
in_ready  out  1  block can accept a request
key  in  192  cipher key, key[191:160] = word w0
in  in  128  ciphertext, byte 0 = in[127:120]
out  out  128  plaintext, same byte order as in
out_valid  out  1  out holds a finished plaintext
out_ready  in  1  consumer accepts out

Behaviour:
- Reset (async, rst_n=0): state IDLE, out=0, out_valid=0, key_cached flag=0.
  - in_ready is 1 after reset.
  - Round-key storage and the cached key register need not be reset.
- Round keys: words w[0..51]; rk[r] = {w[4r],w[4r+1],w[4r+2],w[4r+3]}, r=0..12; rk0 = key[191:64].
- IDLE: in_ready=1.
  - On in_valid: latch in into the state register and key into w[0..5].
  - If KEY_REUSE=1, key_cached=1 and key equals the cached key: go to ROUNDS with rnd=12, skipping KEYGEN.
  - Otherwise: rcon=32'h01000000, kcnt=0, go to KEYGEN.
- KEYGEN: 8 cycles, kcnt=0..7.
  - Each cycle applies key_expansion_192 to w[6k..6k+5] with rcon, writes w[6k+6..6k+11], and doubles rcon in GF(2^8). Words beyond w51 are discarded.
  - After kcnt=7: key_cached=1, store the cached key, go to ROUNDS with rnd=12.
- ROUNDS: 13 cycles.
  - rnd=12: state <= state ^ rk12.
  - rnd=11..1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[rnd]).
  - rnd=0: out <= InvSubBytes(InvShiftRows(state)) ^ rk0, out_valid <= 1, go to DONE.
  - rnd decrements each cycle.
- DONE: out_valid=1, out stable. On out_ready: out_valid <= 0, go to IDLE. out keeps its last value.
- in_ready=0 in KEYGEN, ROUNDS and DONE; in_valid is ignored there, so a request is never lost or half-accepted.
- Latency, counted from the accepting edge T to the edge where out_valid rises:
  - T+21 with key expansion (1 + 8 + 13 − 1 boundary: 8 KEYGEN edges plus 13 ROUNDS edges).
  - T+13 on a key-reuse hit.
- Back-to-back throughput: one block per (latency + 1 + out wait) cycles. No overlap of requests.
- Reset asserted mid-KEYGEN or mid-ROUNDS: immediate return to IDLE, out_valid=0, key_cached=0. Partial round keys are never reused.
- out_ready held high while out_valid=0 has no effect.

Test Plan:
- FIPS-197 C.2: key 000102030405060708090a0b0c0d0e0f1011121314151617, in dda97ca4864cdfe06eaf70a0ec0d7191 -> out 00112233445566778899aabbccddeeff, out_valid rises exactly 21 edges after acceptance.
- Same key, second ciphertext, KEY_REUSE=1 -> correct plaintext after 13 edges. With KEY_REUSE=0 -> 21 edges.
- Round trip: 200 random key/plaintext pairs through enc192, result into dec192_iter -> out equals the original plaintext every time. Interleave key changes and reuse.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out stable, in_ready=0, an in_valid pulse is ignored. Release -> one transfer, then IDLE with in_ready=1.
- Reset mid-operation: drop rst_n during KEYGEN kcnt=3 and again at ROUNDS rnd=6 -> out_valid=0 and in_ready=1 immediately. The next request with the same key takes the 21-edge path and decrypts correctly.
- in_valid held high continuously with a new ciphertext each accept -> each request is accepted only in IDLE. Output order and values match the inputs.
